id_ex_stage_reg: RTL and testbench



---
 rtl/id_ex_stage_reg.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register for a 5-stage MIPS pipeline.
// It extends the 16-bit immediate, latches the operands, addresses and control
// bundle into EX, and applies the WB-to-ID register-file bypass.
// The optional macro IDEX_BUBBLE_CNT_EN adds a saturating bubble counter.
//
// Pipeline control: there is no valid/ready handshake. flush and stall are
// sampled on every rising clock edge, with priority rst > flush > stall > load.
// - flush forces a bubble into EX.
// - stall holds EX. Only a WB write to a held source register may refresh it.
// - Otherwise the ID slot is loaded. An invalid ID slot loads as a bubble.
// A bubble is all-zero, including ex_valid and ex_ctrl.
// All outputs come straight from registers, so there is no input-to-output
// combinational path.
module id_ex_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [15:0]       id_imm,
  input  logic [1:0]        id_ext_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_imm32,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  // The extension and bypass logic below assumes a 32-bit datapath.
  if (DATA_W != 32) begin : g_bad_data_w
    $error("id_ex_stage_reg: DATA_W must be 32");
  end

  logic              r_valid;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [DATA_W-1:0] r_imm32;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [CTRL_W-1:0] r_ctrl;

  logic [DATA_W-1:0] w_imm32;
  logic              w_wb_live;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic              w_hold_rs_hit;
  logic              w_hold_rt_hit;
  logic              w_bubble;

  // Immediate extension selected by the decoded extension mode.
  always_comb begin
    w_imm32 = '0;
    case (id_ext_op)
      2'b00:   w_imm32 = {16'h0000, id_imm};
      2'b01:   w_imm32 = {{16{id_imm[15]}}, id_imm};
      2'b10:   w_imm32 = {id_imm, 16'h0000};
      default: w_imm32 = {27'd0, id_imm[10:6]};
    endcase
  end

  // A WB write to register 0 is never forwarded.
  assign w_wb_live     = wb_we && (wb_addr != 5'd0);
  assign w_rs_data     = (w_wb_live && (wb_addr == id_rs)) ? wb_data : id_rs_data;
  assign w_rt_data     = (w_wb_live && (wb_addr == id_rt)) ? wb_data : id_rt_data;
  assign w_hold_rs_hit = w_wb_live && (wb_addr == r_rs);
  assign w_hold_rt_hit = w_wb_live && (wb_addr == r_rt);

  // A bubble is loaded on a flush, or on a load edge with an empty ID slot.
  assign w_bubble = flush || (!stall && !id_valid);

  // EX slot register: reset, then bubble, then hold with WB refresh, then load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc_plus4 <= '0;
      r_imm32    <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_pc_plus4 <= '0;
      r_imm32    <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
    end else if (stall) begin
      // The held instruction still needs to see a result retiring in WB.
      if (w_hold_rs_hit) r_rs_data <= wb_data;
      if (w_hold_rt_hit) r_rt_data <= wb_data;
    end else begin
      r_valid    <= 1'b1;
      r_pc_plus4 <= id_pc_plus4;
      r_imm32    <= w_imm32;
      r_rs_data  <= w_rs_data;
      r_rt_data  <= w_rt_data;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_ctrl     <= id_ctrl;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc_plus4 = r_pc_plus4;
  assign ex_imm32    = r_imm32;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign ex_ctrl     = r_ctrl;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Saturating count of edges that load a bubble. Stall edges are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed and randomized bench for id_ex_stage_reg.
// It builds with or without IDEX_BUBBLE_CNT_EN.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] ctrl;
  } ex_t;

  localparam int OUT_W = $bits(ex_t);

  logic        clk, rst, flush, stall, id_valid;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, wb_data;
  logic [15:0] id_imm, id_ctrl;
  logic [1:0]  id_ext_op;
  logic [4:0]  id_rs, id_rt, id_rd, wb_addr;
  logic        wb_we;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_imm32, ex_rs_data, ex_rt_data;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_ctrl;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  id_ex_stage_reg #(.CTRL_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .id_valid(id_valid),
    .id_pc_plus4(id_pc_plus4), .id_imm(id_imm), .id_ext_op(id_ext_op),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_imm32(ex_imm32),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
`ifdef IDEX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard.
  logic [OUT_W-1:0] exp_q[$];
  ex_t              m;
  logic [31:0]      m_bub;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: immediate extension expressed as arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
    int unsigned u;
    u = 32'(imm);
    case (op)
      2'd0:    return u;
      2'd1:    return (u >= 32768) ? (u + 32'hFFFF_0000) : u;
      2'd2:    return u * 65536;
      default: return (u / 64) % 32;
    endcase
  endfunction

  // Reference model: advance the EX slot by one clock edge.
  task automatic model_edge();
    logic wb_live;
    wb_live = wb_we && (wb_addr != 0);
    if (flush || (!stall && !id_valid)) begin
      m = '0;
      if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    end else if (stall) begin
      if (wb_live && wb_addr == m.rs) m.rsd = wb_data;
      if (wb_live && wb_addr == m.rt) m.rtd = wb_data;
    end else begin
      m.valid = 1'b1;
      m.pc    = id_pc_plus4;
      m.imm   = ref_ext(id_imm, id_ext_op);
      m.rsd   = (wb_live && wb_addr == id_rs) ? wb_data : id_rs_data;
      m.rtd   = (wb_live && wb_addr == id_rt) ? wb_data : id_rt_data;
      m.rs    = id_rs;
      m.rt    = id_rt;
      m.rd    = id_rd;
      m.ctrl  = id_ctrl;
    end
  endtask

  task automatic compare_all(input ex_t e);
    check("ex_valid", 64'(ex_valid), 64'(e.valid));
    check("ex_pc_plus4", 64'(ex_pc_plus4), 64'(e.pc));
    check("ex_imm32", 64'(ex_imm32), 64'(e.imm));
    check("ex_rs_data", 64'(ex_rs_data), 64'(e.rsd));
    check("ex_rt_data", 64'(ex_rt_data), 64'(e.rtd));
    check("ex_addrs", 64'({ex_rs, ex_rt, ex_rd}), 64'({e.rs, e.rt, e.rd}));
    check("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
`ifdef IDEX_BUBBLE_CNT_EN
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
`endif
  endtask

  // Driver tasks. Inputs change 1 time unit after an edge, away from the next one.
  task automatic step();
    ex_t e;
    model_edge();
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare_all(e);
  endtask

  task automatic drive_id(input logic [15:0] imm, input logic [1:0] op,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid    = 1'b1;
    id_pc_plus4 = $urandom;
    id_ctrl     = 16'($urandom_range(1, 16'hFFFF));
    id_imm      = imm;
    id_ext_op   = op;
    id_rs_data  = rsd;
    id_rt_data  = rtd;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    wb_we   = we;
    wb_addr = addr;
    wb_data = data;
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b1;
    #2;
    m = '0;
    m_bub = '0;
    compare_all(m);
    check({tag, "_valid"}, 64'(ex_valid), 64'd0);
    rst = 1'b0;
  endtask

  logic [15:0] imm_a;
  logic [31:0] held_rs;

  initial begin
    rst = 1'b1; flush = 0; stall = 0; id_valid = 0;
    id_pc_plus4 = 0; id_imm = 0; id_ext_op = 0; id_rs_data = 0; id_rt_data = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_ctrl = 0;
    set_wb(0, 0, 0);
    m = '0;
    m_bub = '0;
    #12;
    compare_all(m);
    rst = 1'b0;

    // Extension modes.
    imm_a = 16'h8001;
    for (int op = 0; op < 4; op++) begin
      drive_id(imm_a, 2'(op), 32'h1, 32'h2, 5'd1, 5'd2, 5'd3);
      step();
      case (op)
        0: check("ext_zero", 64'(ex_imm32), 64'h0000_8001);
        1: check("ext_sign", 64'(ex_imm32), 64'hFFFF_8001);
        2: check("ext_lui", 64'(ex_imm32), 64'h8001_0000);
        default: check("ext_shamt", 64'(ex_imm32), 64'h0000_0000);
      endcase
    end
    drive_id(16'h07C0, 2'd3, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3);
    step();
    check("ext_shamt_1f", 64'(ex_imm32), 64'h0000_001F);

    // Stall hold over three edges while the ID inputs keep changing.
    drive_id(16'h0, 2'd0, 32'h1234_5678, 32'h0, 5'd9, 5'd10, 5'd11);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(16'($urandom), 2'($urandom), $urandom, $urandom, 5'd12, 5'd13, 5'd14);
      step();
      check("stall_rs_hold", 64'(ex_rs_data), 64'h1234_5678);
      check("stall_valid", 64'(ex_valid), 64'd1);
    end
    stall = 1'b0;
    step();
    check("post_stall_rs", 64'(ex_rs_data), 64'(id_rs_data));

    // A flush on the same edge as a stall wins.
    flush = 1'b1; stall = 1'b1;
    step();
    check("flush_stall_valid", 64'(ex_valid), 64'd0);
    check("flush_stall_ctrl", 64'(ex_ctrl), 64'd0);
`ifdef IDEX_BUBBLE_CNT_EN
    check("flush_stall_cnt", 64'(bubble_cnt), 64'd1);
`endif
    flush = 1'b0; stall = 1'b0;

    // Bypass on the load path, and register 0 never bypassed.
    drive_id(16'h0, 2'd0, 32'h0, 32'h5, 5'd8, 5'd4, 5'd1);
    set_wb(1, 5'd8, 32'hDEAD_BEEF);
    step();
    check("byp_load_rs", 64'(ex_rs_data), 64'hDEAD_BEEF);
    id_rs = 5'd0;
    set_wb(1, 5'd0, 32'hDEAD_BEEF);
    step();
    check("byp_r0_rs", 64'(ex_rs_data), 64'h0);

    // Bypass on the stall path.
    drive_id(16'h0, 2'd0, 32'h7777_0000, 32'h1111_1111, 5'd6, 5'd3, 5'd2);
    set_wb(0, 0, 0);
    step();
    stall = 1'b1;
    set_wb(1, 5'd3, 32'hCAFE_0001);
    step();
    check("byp_stall_rt", 64'(ex_rt_data), 64'hCAFE_0001);
    check("byp_stall_rs", 64'(ex_rs_data), 64'h7777_0000);
    stall = 1'b0;
    set_wb(0, 0, 0);

    // Asynchronous reset between edges while the EX slot is valid.
    drive_id(16'h1234, 2'd1, 32'h5, 32'h6, 5'd7, 5'd8, 5'd9);
    step();
    check("pre_rst_valid", 64'(ex_valid), 64'd1);
    async_reset_check("async_rst");
    step();
    check("post_rst_load", 64'(ex_valid), 64'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      flush    = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_pc_plus4 = $urandom;
      id_imm      = 16'($urandom);
      id_ext_op   = 2'($urandom);
      id_rs_data  = $urandom;
      id_rt_data  = $urandom;
      id_rs       = 5'($urandom_range(0, 7));
      id_rt       = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom);
      id_ctrl     = 16'($urandom);
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 49) == 0) begin
        held_rs = ex_rs_data;
        async_reset_check("rand_rst");
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
